conv_host_loader: RTL and testbench

- Host-side initiator for the binary 3x3 XNOR convolution engine.
- Accepts an image stream and writes it into the input SRAM in the engine's layout: a dimension word, then N row words per image, then the 16'h00FF terminator.
- Pulses dut_run, waits for the engine's busy window, then reads the output SRAM and streams the result words out with valid/ready backpressure.

---
 rtl/conv_host_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_conv_host_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_host_loader.sv
// Host-side initiator for the binary 3x3 XNOR convolution engine: loads images into the
// input SRAM, starts the engine, waits out its busy window, then streams the results out.
module conv_host_loader #(
  parameter int                ADDR_W       = 12,
  parameter int                DATA_W       = 16,
  parameter logic [DATA_W-1:0] TERM_WORD    = 16'h00FF,
  parameter int                BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] host_sram_write_address,
  output logic [DATA_W-1:0] host_sram_write_data,
  output logic              host_sram_write_enable,
  output logic              dut_run,
  input  logic              dut_busy,
  output logic [ADDR_W-1:0] host_osram_read_address,
  input  logic [DATA_W-1:0] osram_host_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              err
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TERM, S_RUN, S_WAIT_HI, S_WAIT_LO, S_DRAIN, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [4:0]          rows_left_q, rows_left_d;
  logic [ADDR_W-1:0]   exp_out_q, exp_out_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                run_q, run_d;
  logic                busy_q, busy_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                inflight_q, inflight_d;
  logic [DATA_W-1:0]   fifo_mem_q [2];
  logic [DATA_W-1:0]   fifo_mem_d [2];
  logic                wp_q, wp_d, rp_q, rp_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
  logic                done_q, done_d;

  logic [4:0]          hdr_n;
  logic                hdr_legal;
  logic                pop;

  assign hdr_n     = in_data[4:0];
  assign hdr_legal = (hdr_n == 5'd10) || (hdr_n == 5'd12) || (hdr_n == 5'd16);

  assign in_ready                = (state_q == S_LOAD);
  assign host_sram_write_address = waddr_q;
  assign host_sram_write_data    = wdata_q;
  assign host_sram_write_enable  = we_q;
  assign dut_run                 = run_q;
  assign host_osram_read_address = rd_addr_q;
  assign out_valid               = (state_q == S_DRAIN) && (cnt_q != 2'd0);
  assign out_data                = fifo_mem_q[rp_q];
  assign out_last                = out_valid && (out_idx_q == exp_out_q - ADDR_W'(1));
  assign done                    = done_q;
  assign err                     = (state_q == S_ERR);
  assign pop                     = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal gets its default before the case so no path infers a latch.
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rows_left_d = rows_left_q;
    exp_out_d   = exp_out_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    run_d       = 1'b0;
    busy_d      = dut_busy;
    to_cnt_d    = to_cnt_q;
    rd_addr_d   = rd_addr_q;
    inflight_d  = 1'b0;
    fifo_mem_d  = fifo_mem_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    cnt_d       = cnt_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: if (in_valid) state_d = S_LOAD;

      S_LOAD: if (in_valid) begin
        // Rejected words are never written; the terminator still needs a slot.
        if (wr_addr_q == '1) begin
          state_d = S_ERR;
        end else if (rows_left_q == 5'd0) begin
          if (!hdr_legal || in_last) begin
            state_d = S_ERR;
          end else begin
            rows_left_d = hdr_n;
            exp_out_d   = exp_out_q + ADDR_W'(hdr_n) - ADDR_W'(2);
            we_d        = 1'b1;
            waddr_d     = wr_addr_q;
            wdata_d     = in_data;
            wr_addr_d   = wr_addr_q + ADDR_W'(1);
          end
        end else if (in_last && rows_left_q != 5'd1) begin
          state_d = S_ERR;
        end else begin
          rows_left_d = rows_left_q - 5'd1;
          we_d        = 1'b1;
          waddr_d     = wr_addr_q;
          wdata_d     = in_data;
          wr_addr_d   = wr_addr_q + ADDR_W'(1);
          if (in_last) state_d = S_TERM;
        end
      end

      S_TERM: begin
        we_d    = 1'b1;
        waddr_d = wr_addr_q;
        wdata_d = TERM_WORD;
        state_d = S_RUN;
      end

      S_RUN: begin
        run_d    = 1'b1;
        to_cnt_d = '0;
        state_d  = S_WAIT_HI;
      end

      S_WAIT_HI: begin
        if (dut_busy)                                  state_d = S_WAIT_LO;
        else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) state_d = S_ERR;
        else                                           to_cnt_d = to_cnt_q + TO_W'(1);
      end

      S_WAIT_LO: if (busy_q && !dut_busy) state_d = S_DRAIN;

      S_DRAIN: begin
        // A read is only issued when the skid FIFO is guaranteed room for its data.
        if (rd_addr_q != exp_out_q && (cnt_q + {1'b0, inflight_q}) < 2'd2) begin
          inflight_d = 1'b1;
          rd_addr_d  = rd_addr_q + ADDR_W'(1);
        end
        if (inflight_q) begin
          fifo_mem_d[wp_q] = osram_host_read_data;
          wp_d             = ~wp_q;
        end
        if (pop) begin
          rp_d      = ~rp_q;
          out_idx_d = out_idx_q + ADDR_W'(1);
        end
        if (inflight_q && !pop)      cnt_d = cnt_q + 2'd1;
        else if (!inflight_q && pop) cnt_d = cnt_q - 2'd1;
        if (pop && out_last) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          wr_addr_d   = '0;
          rows_left_d = '0;
          exp_out_d   = '0;
          to_cnt_d    = '0;
          rd_addr_d   = '0;
          out_idx_d   = '0;
          wp_d        = 1'b0;
          rp_d        = 1'b0;
          cnt_d       = 2'd0;
        end
      end

      S_ERR:   ;
      default: state_d = S_ERR;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      rows_left_q <= '0;
      exp_out_q   <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      to_cnt_q    <= '0;
      rd_addr_q   <= '0;
      inflight_q  <= 1'b0;
      // NOTE: the two skid entries are reset so out_data is 0 out of reset; a deep array would not be.
      fifo_mem_q  <= '{default: '0};
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      cnt_q       <= 2'd0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rows_left_q <= rows_left_d;
      exp_out_q   <= exp_out_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      to_cnt_q    <= to_cnt_d;
      rd_addr_q   <= rd_addr_d;
      inflight_q  <= inflight_d;
      fifo_mem_q  <= fifo_mem_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      out_idx_q   <= out_idx_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_host_loader.sv
// Self-checking bench for conv_host_loader: random image streams and output backpressure
// checked against a queue-based model of the SRAM layout and the expected result stream.
module tb_conv_host_loader;

  localparam int BUSY_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [11:0] host_sram_write_address, host_osram_read_address;
  logic [15:0] host_sram_write_data, osram_host_read_data, out_data;
  logic        host_sram_write_enable, dut_run, dut_busy, out_valid, out_ready, out_last, done, err;

  conv_host_loader #(.BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .reset_b(reset_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .host_sram_write_address(host_sram_write_address),
    .host_sram_write_data(host_sram_write_data),
    .host_sram_write_enable(host_sram_write_enable),
    .dut_run(dut_run), .dut_busy(dut_busy),
    .host_osram_read_address(host_osram_read_address),
    .osram_host_read_data(osram_host_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [62:0] outs_vec;
  assign outs_vec = {in_ready, host_sram_write_address, host_sram_write_data, host_sram_write_enable,
                     dut_run, host_osram_read_address, out_valid, out_data, out_last, done, err};

  // Output SRAM model: synchronous read, data one cycle after the address.
  logic [15:0] osram [0:4095];
  always @(posedge clk) osram_host_read_data <= osram[host_osram_read_address];

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [27:0] wr_log[$];
  logic [15:0] got[$];
  int  run_cnt, run_cyc, done_cnt, done_cyc, last_cnt, last_idx, last_cyc, err_cyc;
  bit  err_seen, stall_prev;
  logic [17:0] stall_vec;

  always @(negedge clk) begin
    if (host_sram_write_enable) wr_log.push_back({host_sram_write_address, host_sram_write_data});
    if (dut_run) begin run_cnt++; run_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err && !err_seen) begin err_seen = 1'b1; err_cyc = cyc; end
    if (stall_prev) check("stall_hold", {out_valid, out_last, out_data}, stall_vec);
    stall_prev = out_valid && !out_ready;
    stall_vec  = {out_valid, out_last, out_data};
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      if (out_last) begin last_cnt++; last_idx = got.size() - 1; last_cyc = cyc; end
    end
  end

  // Engine model: raises busy two cycles after the run pulse and holds it busy_len cycles.
  bit engine_on = 1'b1;
  int busy_len  = 30;
  initial begin
    dut_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dut_run && engine_on) begin
        repeat (2) @(posedge clk);
        #1 dut_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 dut_busy = 1'b0;
      end
    end
  end

  bit rdy_random = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rdy_random ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Reference model: the expected input-SRAM image and result count follow from the dims alone.
  int          dims[$];
  logic [15:0] s_data[$];
  bit          s_last[$];
  logic [27:0] exp_wr[$];
  int          exp_out;

  task automatic build_stream();
    int a;
    logic [15:0] w;
    a = 0; exp_out = 0;
    s_data.delete(); s_last.delete(); exp_wr.delete();
    for (int i = 0; i < dims.size(); i++) begin
      w = 16'(dims[i]);
      s_data.push_back(w); s_last.push_back(1'b0); exp_wr.push_back({12'(a), w}); a++;
      exp_out += dims[i] - 2;
      for (int r = 0; r < dims[i]; r++) begin
        w = 16'($urandom);
        s_data.push_back(w);
        s_last.push_back(i == dims.size() - 1 && r == dims[i] - 1);
        exp_wr.push_back({12'(a), w}); a++;
      end
    end
    exp_wr.push_back({12'(a), 16'h00FF});
    for (int i = 0; i < 4096; i++) osram[i] = 16'($urandom);
  endtask

  task automatic clear_obs();
    wr_log.delete(); got.delete();
    run_cnt = 0; done_cnt = 0; last_cnt = 0; last_idx = -1;
    err_seen = 1'b0; stall_prev = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    reset_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;
    clear_obs();
  endtask

  // Called at posedge+1; returns at posedge+1 after the last accepted word.
  task automatic drive(input int stop_after, output int accepted);
    bit acc;
    int b;
    accepted = 0;
    for (int i = 0; i < s_data.size(); i++) begin
      if (stop_after >= 0 && accepted >= stop_after) break;
      in_valid = 1'b1; in_data = s_data[i]; in_last = s_last[i];
      acc = 1'b0; b = 0;
      while (!acc && b < 50) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1; b++;
      end
      if (!acc) begin
        check("load_accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      accepted++;
      in_valid = 1'b0; in_last = 1'b0;
      if (i < s_data.size() - 1 && $urandom_range(3) == 0) begin @(posedge clk); #1; end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_full(input string tag);
    int n, b;
    build_stream();
    drive(-1, n);
    b = 0;
    while (done_cnt == 0 && b < 4000) begin @(posedge clk); #1; b++; end
    check({tag, "_done_seen"}, done_cnt > 0, 1);
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      check($sformatf("%s_wr[%0d]", tag, i), wr_log[i], exp_wr[i]);
    check({tag, "_run_pulses"}, run_cnt, 1);
    check({tag, "_out_count"}, got.size(), exp_out);
    for (int i = 0; i < got.size() && i < exp_out; i++)
      check($sformatf("%s_out[%0d]", tag, i), got[i], osram[i]);
    check({tag, "_last_count"}, last_cnt, 1);
    check({tag, "_last_idx"}, last_idx, exp_out - 1);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_delay"}, done_cyc - last_cyc, 1);
    check({tag, "_err_low"}, err, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b;
    clear_obs();
    #3 check("reset_outs", outs_vec, 63'd0);

    // One 10x10 image, always-ready sink.
    do_reset();
    check("idle_outs", outs_vec, 63'd0);
    dims = '{10};
    run_full("t1");
    check("t1_exp_out", exp_out, 8);

    // Three images back to back, random backpressure.
    rdy_random = 1'b1;
    do_reset();
    dims = '{16, 12, 10};
    run_full("t2");
    check("t2_exp_out", exp_out, 32);

    // Illegal header.
    do_reset();
    dims = '{11};
    build_stream();
    s_data = '{16'h000B}; s_last = '{1'b0};
    drive(-1, n);
    @(negedge clk);
    check("t3_err", err, 1);
    check("t3_in_ready", in_ready, 0);
    check("t3_no_write", wr_log.size(), 0);
    repeat (40) @(posedge clk);
    #1;
    check("t3_no_run", run_cnt, 0);
    check("t3_err_sticky", err, 1);

    // Engine never goes busy: timeout.
    do_reset();
    engine_on = 1'b0;
    dims = '{10};
    build_stream();
    drive(-1, n);
    b = 0;
    while (!err_seen && b < 300) begin @(posedge clk); #1; b++; end
    check("t4_err_seen", err_seen, 1);
    check("t4_timeout_cycles", err_cyc - run_cyc, BUSY_TIMEOUT);
    check("t4_run_pulses", run_cnt, 1);
    check("t4_out_valid", out_valid, 0);
    engine_on = 1'b1;

    // Reset in the middle of a load, then a fresh 12x12 load.
    do_reset();
    dims = '{12};
    build_stream();
    drive(5, n);
    #2 reset_b = 1'b0;
    #1 check("t6_async_reset_outs", outs_vec, 63'd0);
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;
    clear_obs();
    run_full("t6");

    // Another random-backpressure pass on a single 16x16 image.
    do_reset();
    dims = '{16};
    run_full("t5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
